// File: rtl/bit_deser_pkg.sv
// Shared definitions for the bit deserializer slice.
//   DEFAULT_WIDTH : default word width in data bits
//   cnt_state_e   : bit-counter occupancy (EMPTY / FILLING / LAST)
//   cnt_width()   : width of a counter that must hold 0..last
package bit_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_LAST
    } cnt_state_e;

    function automatic int cnt_width(input int last);
        return (last < 1) ? 1 : $clog2(last + 1);
    endfunction

endpackage

// File: rtl/bit_deserializer_if.sv
// Serial-in / word-out handshake bundle of the bit deserializer.
//   ser_valid, ser_data, frame_start, ser_ready : serial beat handshake
//   out_valid, out_data, out_ready              : word handshake
//   frame_err, parity_err                       : status flags
// Modports: slave = deserializer side, master = link/datapath side.
interface bit_deserializer_if
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             ser_valid;
    logic             ser_data;
    logic             frame_start;
    logic             ser_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             frame_err;
    logic             parity_err;

    modport slave (
        input  ser_valid, ser_data, frame_start, out_ready,
        output ser_ready, out_valid, out_data, frame_err, parity_err
    );

    modport master (
        output ser_valid, ser_data, frame_start, out_ready,
        input  ser_ready, out_valid, out_data, frame_err, parity_err
    );
endinterface

// File: rtl/bit_deser_out_reg.sv
// One-word holding register with valid/ready handshake.
//   i_load  : a completed word is presented this cycle
//   i_data  : completed word, i_perr : its parity flag
//   i_ready : downstream accepts the held word
//   o_valid / o_data / o_perr : held word and flag
// A load always wins over a consume, so a word completing in the same
// cycle the old one leaves keeps o_valid high without a bubble.
module bit_deser_out_reg
    import bit_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_perr,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_perr
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_perr  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_perr  <= i_perr;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_perr  = r_perr;
endmodule

// File: rtl/bit_deserializer.sv
// Bit deserializer: gathers one serial bit per accepted beat into
// WIDTH-bit words and presents them through a one-word holding register.
// Ports: clk, rst_n (async active-low), bus (bit_deserializer_if.slave).
// Parameters: WIDTH (data bits, >=2), MSB_FIRST (0: first bit -> bit 0,
// 1: first bit -> bit WIDTH-1).
// Build option: define BIT_DESER_PARITY_EN to expect one trailing even
// parity bit per word and report mismatches on parity_err; otherwise
// parity_err stays 0.
module bit_deserializer
    import bit_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    bit_deserializer_if.slave   bus
);
`ifdef BIT_DESER_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int              CNT_W     = cnt_width(LAST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
    localparam int              FIRST_POS = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;

    cnt_state_e       w_state;
    int               w_pos;
    logic [WIDTH-1:0] w_ins;
    logic [WIDTH-1:0] w_fresh;
    logic [WIDTH-1:0] w_word;
    logic             w_perr;
    logic             w_ser_ready;
    logic             w_acc;
    logic             w_complete;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic             w_out_perr;

    always_comb begin
        if (r_cnt == '0)
            w_state = ST_EMPTY;
        else if (r_cnt == LAST_CNT)
            w_state = ST_LAST;
        else
            w_state = ST_FILLING;
    end

    // Only the word-completing beat can stall; earlier bits never need the
    // output register.
    assign w_ser_ready = !((w_state == ST_LAST) && w_out_valid && !bus.out_ready);
    assign w_acc       = bus.ser_valid && w_ser_ready;
    assign w_complete  = w_acc && !bus.frame_start && (w_state == ST_LAST);

    // Position of the incoming bit; the parity beat (cnt == WIDTH) maps
    // outside the data range and so lands nowhere.
    assign w_pos = (MSB_FIRST != 0) ? (WIDTH - 1 - int'(r_cnt)) : int'(r_cnt);

    always_comb begin
        w_ins   = r_shift;
        w_fresh = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == w_pos)
                w_ins[i] = bus.ser_data;
            if (i == FIRST_POS)
                w_fresh[i] = bus.ser_data;
        end
    end

`ifdef BIT_DESER_PARITY_EN
    // Data bits are already complete; the final beat is the parity bit.
    assign w_word = r_shift;
    assign w_perr = (^r_shift) ^ bus.ser_data;
`else
    assign w_word = w_ins;
    assign w_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_acc) begin
                if (bus.frame_start) begin
                    // Resynchronise: this beat is bit 0 of a new word.
                    r_shift     <= w_fresh;
                    r_cnt       <= CNT_W'(1);
                    r_frame_err <= (w_state != ST_EMPTY);
                end else if (w_state == ST_LAST) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_shift <= w_ins;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    bit_deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_complete),
        .i_data  (w_word),
        .i_perr  (w_perr),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_perr  (w_out_perr)
    );

    assign bus.ser_ready  = w_ser_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_out_data;
    assign bus.parity_err = w_out_perr;
    assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_bit_deserializer.sv
module tb_bit_deserializer;
    localparam int W = 8;
`ifdef BIT_DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk;
    logic rst_n;
    logic s_valid, s_data, s_fs, s_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits of the current partial word plus the held word.
    int           m_bits[$];
    logic         m_valid;
    logic [W-1:0] m_d0, m_d1;
    logic         m_ferr, m_perr;

    bit_deserializer_if #(.WIDTH(W)) if0 ();
    bit_deserializer_if #(.WIDTH(W)) if1 ();

    assign if0.ser_valid   = s_valid;
    assign if0.ser_data    = s_data;
    assign if0.frame_start = s_fs;
    assign if0.out_ready   = s_ready;
    assign if1.ser_valid   = s_valid;
    assign if1.ser_data    = s_data;
    assign if1.frame_start = s_fs;
    assign if1.out_ready   = s_ready;

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    bit_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_valid = 1'b0;
        m_d0    = '0;
        m_d1    = '0;
        m_ferr  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid_lsb", if0.out_valid, m_valid);
        chk("out_valid_msb", if1.out_valid, m_valid);
        chk("out_data_lsb", if0.out_data, m_d0);
        chk("out_data_msb", if1.out_data, m_d1);
        chk("frame_err_lsb", if0.frame_err, m_ferr);
        chk("frame_err_msb", if1.frame_err, m_ferr);
        chk("parity_err_lsb", if0.parity_err, m_perr);
        chk("parity_err_msb", if1.parity_err, m_perr);
    endtask

    // One clock cycle: drive inputs, check ready mid-cycle, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input logic v, input logic d, input logic fs, input logic rdy);
        logic         exp_rdy, acc, load, p;
        logic [W-1:0] w0, w1;
        s_valid = v;
        s_data  = d;
        s_fs    = fs;
        s_ready = rdy;
        @(negedge clk);
        exp_rdy = !((m_bits.size() == NB - 1) && m_valid && !rdy);
        chk("ser_ready_lsb", if0.ser_ready, exp_rdy);
        chk("ser_ready_msb", if1.ser_ready, exp_rdy);
        acc    = v && exp_rdy;
        load   = 1'b0;
        m_ferr = 1'b0;
        if (acc) begin
            if (fs) begin
                m_ferr = (m_bits.size() != 0);
                m_bits.delete();
                m_bits.push_back(int'(d));
            end else begin
                m_bits.push_back(int'(d));
                if (m_bits.size() == NB) begin
                    w0 = '0;
                    w1 = '0;
                    p  = 1'b0;
                    for (int i = 0; i < W; i++) begin
                        w0 = w0 | (W'(m_bits[i]) << i);
                        w1 = w1 | (W'(m_bits[i]) << (W - 1 - i));
                        p  = p ^ (m_bits[i] != 0);
                    end
`ifdef BIT_DESER_PARITY_EN
                    m_perr = p ^ (m_bits[W] != 0);
`else
                    m_perr = 1'b0;
`endif
                    m_d0 = w0;
                    m_d1 = w1;
                    load = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (load)
            m_valid = 1'b1;
        else if (m_valid && rdy)
            m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Send beats lo..hi of a word, beat k carrying bits[k].
    task automatic send(input logic [15:0] bits, input int lo, input int hi, input logic rdy);
        for (int k = lo; k <= hi; k++)
            step(1'b1, bits[k], 1'b0, rdy);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_fs    = 1'b0;
        rst_n   = 1'b0;
        #2;
        model_reset();
        chk("rst_valid", if0.out_valid, 1'b0);
        chk("rst_data", if0.out_data, '0);
        chk("rst_ferr", if0.frame_err, 1'b0);
        chk("rst_perr", if0.parity_err, 1'b0);
        chk("rst_ready", if0.ser_ready, 1'b1);
        chk("rst_valid_msb", if1.out_valid, 1'b0);
        chk("rst_data_msb", if1.out_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] word_a5, word_3c, word_01;

    initial begin
        s_valid = 1'b0;
        s_data  = 1'b0;
        s_fs    = 1'b0;
        s_ready = 1'b1;
        rst_n   = 1'b0;
        model_reset();
        word_a5 = 16'h00A5;             // even parity bit (bit 8) is 0
        word_3c = 16'h003C;             // even parity bit (bit 8) is 0
        word_01 = 16'h0101;             // even parity bit (bit 8) is 1
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();

        // Basic words, ready always high.
        send(word_a5, 0, NB - 1, 1'b1);
        chk("a5_valid", if0.out_valid, 1'b1);
        chk("a5_lsb", if0.out_data, 8'hA5);
        chk("a5_msb", if1.out_data, 8'hA5);
        chk("a5_ferr", if0.frame_err, 1'b0);
        chk("a5_perr", if0.parity_err, 1'b0);
        send(word_3c, 0, NB - 1, 1'b1);
        chk("3c_lsb", if0.out_data, 8'h3C);
        chk("3c_msb", if1.out_data, 8'h3C);

        // Backpressure: hold A5, stall only the completing beat of 3C.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(word_a5, 0, NB - 1, 1'b0);
        send(word_3c, 0, NB - 2, 1'b0);
        step(1'b1, word_3c[NB-1], 1'b0, 1'b0);
        step(1'b1, word_3c[NB-1], 1'b0, 1'b0);
        chk("bp_stall_ready", if0.ser_ready, 1'b0);
        chk("bp_hold_data", if0.out_data, 8'hA5);
        chk("bp_hold_valid", if0.out_valid, 1'b1);
        step(1'b1, word_3c[NB-1], 1'b0, 1'b1);
        chk("bp_reload_valid", if0.out_valid, 1'b1);
        chk("bp_reload_data", if0.out_data, 8'h3C);

        // Frame resync: 3 bits, frame_start with bit 1, then the rest of 0x01.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h0003, 0, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("fs_ferr_pulse", if0.frame_err, 1'b1);
        send(word_01, 1, 1, 1'b1);
        chk("fs_ferr_clear", if0.frame_err, 1'b0);
        send(word_01, 2, NB - 1, 1'b1);
        chk("fs_word_lsb", if0.out_data, 8'h01);
        chk("fs_word_msb", if1.out_data, 8'h80);
        chk("fs_perr", if0.parity_err, 1'b0);

`ifdef BIT_DESER_PARITY_EN
        send(16'h01A5, 0, NB - 1, 1'b1);
        chk("par_bad", if0.parity_err, 1'b1);
        send(16'h00A5, 0, NB - 1, 1'b1);
        chk("par_good", if0.parity_err, 1'b0);
`endif

        // Reset mid-word, with a word held at the output.
        send(word_a5, 0, NB - 1, 1'b0);
        send(16'h001F, 0, 4, 1'b0);
        do_reset();
        send(word_3c, 0, NB - 1, 1'b1);
        chk("post_rst_lsb", if0.out_data, 8'h3C);
        chk("post_rst_ferr", if0.frame_err, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
                 ($urandom % 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
